// File: rtl/decoder_pulse.sv
// decoder_pulse
// Registered, width-guaranteed one-hot strobe generator. A W-bit selector is
// captured on a request strobe and the selected output line is held high for
// PULSE cycles, followed by at least GAP all-zero cycles (break-before-make).
// One further request can be parked in a pending slot while a pulse is in
// flight; a request arriving while that slot is occupied is dropped and
// flagged on the sticky ovf output.
//
// Ports:
//   clk_sys  in   system clock, rising edge
//   clr      in   asynchronous active-high reset
//   req      in   request strobe, sampled on the rising edge
//   i        in   [0:W-1] selector, i[0] is the MSB
//   o        out  [0:2**W-1] registered one-hot outputs, o[k] for k = value of i
//   busy     out  high while a pulse/gap is in progress or a request is pending
//   done     out  one-cycle pulse in the first gap cycle after each pulse
//   ovf      out  sticky: a request was dropped; cleared only by clr
module decoder_pulse #(
  parameter int W     = 3,
  parameter int PULSE = 4,
  parameter int GAP   = 1
) (
  input  logic             clk_sys,
  input  logic             clr,
  input  logic             req,
  input  logic [0:W-1]     i,
  output logic [0:2**W-1]  o,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int N    = 2 ** W;
  localparam int MAXC = (PULSE > GAP) ? PULSE : GAP;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_GAP
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [0:W-1]    cur_reg, cur_next;
  logic [0:W-1]    pend_reg, pend_next;
  logic            pend_valid_reg, pend_valid_next;
  logic            ovf_reg, ovf_next;
  logic            done_next;
  logic            busy_next;
  logic [0:N-1]    o_reg, o_next;
  logic            done_reg, busy_reg;

  always_ff @(posedge clk_sys or posedge clr) begin
    if (clr) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      cur_reg        <= '0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      ovf_reg        <= 1'b0;
      done_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      o_reg          <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      cur_reg        <= cur_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      ovf_reg        <= ovf_next;
      done_reg       <= done_next;
      busy_reg       <= busy_next;
      o_reg          <= o_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    cur_next        = cur_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    ovf_next        = ovf_reg;
    done_next       = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        // The pending slot is always empty here, so a request starts directly.
        if (req) begin
          state_next = ST_ACTIVE;
          cur_next   = i;
          cnt_next   = CW'(PULSE - 1);
        end
      end

      ST_ACTIVE: begin
        if (cnt_reg == '0) begin
          state_next = ST_GAP;
          cnt_next   = CW'(GAP - 1);
          // done is registered, so it appears in the first gap cycle.
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
        if (req) begin
          if (!pend_valid_reg) begin
            pend_next       = i;
            pend_valid_next = 1'b1;
          end else begin
            ovf_next = 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (cnt_reg == '0) begin
          if (pend_valid_reg) begin
            // Consume the pending slot; a request on this same edge refills it.
            state_next      = ST_ACTIVE;
            cur_next        = pend_reg;
            cnt_next        = CW'(PULSE - 1);
            pend_next       = i;
            pend_valid_next = req;
          end else if (req) begin
            // Would have been parked and consumed on the same edge: start it
            // straight away rather than stranding it behind an IDLE state.
            state_next = ST_ACTIVE;
            cur_next   = i;
            cnt_next   = CW'(PULSE - 1);
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
          if (req) begin
            if (!pend_valid_reg) begin
              pend_next       = i;
              pend_valid_next = 1'b1;
            end else begin
              ovf_next = 1'b1;
            end
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE) || pend_valid_next;
  end

  // Output decode works on next-state values so the lines are driven straight
  // from flops, giving the 1-cycle latency from sampled req to o.
  for (genvar gi = 0; gi < N; gi++) begin : g_dec
    assign o_next[gi] = (state_next == ST_ACTIVE) && (cur_next == W'(gi));
  end

  assign o    = o_reg;
  assign busy = busy_reg;
  assign done = done_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_decoder_pulse.sv
// Directed testbench for decoder_pulse: default instance (W=3, PULSE=4, GAP=1)
// plus a W=4, PULSE=1, GAP=3 instance. Cycle n means "just after edge n-1",
// where edge 0 is the edge that samples the first req of a scenario.
module tb_decoder_pulse;

  logic        clk_sys = 1'b0;
  logic        clr     = 1'b1;
  logic        req_a   = 1'b0;
  logic [0:2]  i_a     = '0;
  logic [0:7]  o_a;
  logic        busy_a, done_a, ovf_a;
  logic        req_b   = 1'b0;
  logic [0:3]  i_b     = '0;
  logic [0:15] o_b;
  logic        busy_b, done_b, ovf_b;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_sys = ~clk_sys;

  decoder_pulse #(.W(3), .PULSE(4), .GAP(1)) dut_a (
    .clk_sys (clk_sys),
    .clr     (clr),
    .req     (req_a),
    .i       (i_a),
    .o       (o_a),
    .busy    (busy_a),
    .done    (done_a),
    .ovf     (ovf_a)
  );

  decoder_pulse #(.W(4), .PULSE(1), .GAP(3)) dut_b (
    .clk_sys (clk_sys),
    .clr     (clr),
    .req     (req_b),
    .i       (i_b),
    .o       (o_b),
    .busy    (busy_b),
    .done    (done_b),
    .ovf     (ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk_a(input string tag, input int n, input logic [7:0] eo,
                       input logic ed, input logic eb, input logic ev);
    chk($sformatf("%s.o@%0d", tag, n),    32'(o_a),    32'(eo));
    chk($sformatf("%s.done@%0d", tag, n), 32'(done_a), 32'(ed));
    chk($sformatf("%s.busy@%0d", tag, n), 32'(busy_a), 32'(eb));
    chk($sformatf("%s.ovf@%0d", tag, n),  32'(ovf_a),  32'(ev));
  endtask

  task automatic do_clr();
    @(negedge clk_sys);
    clr = 1'b1;
    @(negedge clk_sys);
    clr = 1'b0;
    tick();
  endtask

  // Single request i=5: o[5] for cycles 1..4, gap+done at 5, idle from 6.
  task automatic run_basic(input string tag);
    logic [7:0] eo;
    for (int c = 0; c <= 6; c++) begin
      req_a = (c == 0);
      i_a   = 3'b101;
      tick();
      eo = (c + 1 <= 4) ? 8'b0000_0100 : 8'b0;
      chk_a(tag, c + 1, eo, (c + 1 == 5), (c + 1 <= 5), 1'b0);
    end
    $display("[TB] %s: single pulse on o[5]", tag);
  endtask

  initial begin
    logic [7:0]  eo;
    logic [15:0] eob;
    int n;

    // Reset state
    #2;
    chk("rst.o_a", 32'(o_a), 32'h0);
    chk("rst.busy_a", 32'(busy_a), 32'h0);
    chk("rst.done_a", 32'(done_a), 32'h0);
    chk("rst.ovf_a", 32'(ovf_a), 32'h0);
    chk("rst.o_b", 32'(o_b), 32'h0);
    chk("rst.busy_b", 32'(busy_b), 32'h0);
    @(negedge clk_sys);
    clr = 1'b0;
    tick();
    $display("[TB] reset: outputs idle");

    run_basic("basic");
    tick();

    // Back-to-back: i=0 at c0, i=7 at c2
    for (int c = 0; c <= 11; c++) begin
      req_a = (c == 0) || (c == 2);
      i_a   = (c == 2) ? 3'd7 : 3'd0;
      tick();
      n  = c + 1;
      eo = (n >= 1 && n <= 4) ? 8'b1000_0000 :
           (n >= 6 && n <= 9) ? 8'b0000_0001 : 8'b0;
      chk_a("b2b", n, eo, (n == 5 || n == 10), (n <= 10), 1'b0);
    end
    $display("[TB] b2b: o[0] then o[7]");
    tick();

    // Overflow: i=1,2,3 at c0,c1,c2; i=3 dropped
    for (int c = 0; c <= 11; c++) begin
      req_a = (c <= 2);
      i_a   = 3'(c + 1);
      tick();
      n  = c + 1;
      eo = (n >= 1 && n <= 4) ? 8'b0100_0000 :
           (n >= 6 && n <= 9) ? 8'b0010_0000 : 8'b0;
      chk_a("ovf", n, eo, (n == 5 || n == 10), (n <= 10), (n >= 3));
    end
    tick();
    tick();
    chk("ovf.sticky", 32'(ovf_a), 32'h1);
    $display("[TB] ovf: i=3 dropped, ovf sticky");
    do_clr();
    chk("ovf.cleared", 32'(ovf_a), 32'h0);

    // Refill on consume: i=1 c0, i=2 c1 (pending), i=6 at last gap edge c5
    for (int c = 0; c <= 16; c++) begin
      req_a = (c == 0) || (c == 1) || (c == 5);
      i_a   = (c == 0) ? 3'd1 : (c == 1) ? 3'd2 : 3'd6;
      tick();
      n  = c + 1;
      eo = (n >= 1 && n <= 4)   ? 8'b0100_0000 :
           (n >= 6 && n <= 9)   ? 8'b0010_0000 :
           (n >= 11 && n <= 14) ? 8'b0000_0010 : 8'b0;
      chk_a("refill", n, eo, (n == 5 || n == 10 || n == 15), (n <= 15), 1'b0);
    end
    $display("[TB] refill: three pulses o[1], o[2], o[6]");
    tick();

    // clr mid-ACTIVE at cycle 2
    req_a = 1'b1;
    i_a   = 3'b101;
    tick();
    req_a = 1'b0;
    chk("abort.o_before", 32'(o_a), 32'h04);
    tick();
    #2;
    clr = 1'b1;
    #1;
    chk("abort.o", 32'(o_a), 32'h0);
    chk("abort.busy", 32'(busy_a), 32'h0);
    chk("abort.done", 32'(done_a), 32'h0);
    @(negedge clk_sys);
    clr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("abort.nodone@%0d", c), 32'(done_a), 32'h0);
      chk($sformatf("abort.o@%0d", c), 32'(o_a), 32'h0);
    end
    $display("[TB] abort: pulse cut by clr");
    run_basic("after_clr");

    // Parameter sweep instance: W=4, PULSE=1, GAP=3, i=15
    for (int c = 0; c <= 5; c++) begin
      req_b = (c == 0);
      i_b   = 4'b1111;
      tick();
      n   = c + 1;
      eob = (n == 1) ? 16'h0001 : 16'h0000;
      chk($sformatf("sweep.o@%0d", n), 32'(o_b), 32'(eob));
      chk($sformatf("sweep.done@%0d", n), 32'(done_b), 32'(n == 2));
      chk($sformatf("sweep.busy@%0d", n), 32'(busy_b), 32'(n <= 4));
      chk($sformatf("sweep.ovf@%0d", n), 32'(ovf_b), 32'h0);
    end
    $display("[TB] sweep: o[15] one cycle, three gap cycles");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/decoder_pulse.md
Name: decoder_pulse

Overview:
- Parametrised, registered successor to the combinational 3-to-8 enable decoder.
- Latches a W-bit selector on a request strobe and drives the selected one-hot output line for a programmable number of clock cycles.
- Inserts a guaranteed all-zero gap after each pulse (break-before-make) and reports completion.
- Buffers one pending request so back-to-back strobes from the control sequencer are not lost.
- Used wherever a decoded control strobe must have a guaranteed width and spacing, e.g. the register/bus strobe generation in the CPU.

Parameters:
- W, 3: selector width; output count is 2**W.
- PULSE, 4: cycles the selected output stays high; legal range 1..255.
- GAP, 1: all-zero cycles after each pulse before the next can start; legal range 1..255.

Ports:
- clk_sys  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous, active-high reset.
- req  in  1  request strobe, sampled on the rising edge.
- i  in  [0:W-1]  selector; i[0] is the MSB. Captured on the same edge as req.
- o  out  [0:2**W-1]  registered one-hot outputs; o[k] is driven where k = binary value of i.
- busy  out  1  high when state is not IDLE or the pending slot is valid.
- done  out  1  one-cycle pulse in the first gap cycle after each pulse.
- ovf  out  1  sticky: a request was dropped. Cleared only by clr.

Behaviour:
- Reset (clr=1, asynchronous):
  - o=0, done=0, busy=0, ovf=0.
  - state=IDLE, pending slot empty, counter=0.
  - Any in-flight pulse is cut off immediately, with no done.
- State machine IDLE -> ACTIVE -> GAP -> (ACTIVE | IDLE):
  - IDLE: on req=1, latch i into the current register and go to ACTIVE. o[i] rises on that same edge, so there is a 1-cycle latency from the sampled req to o.
  - ACTIVE: o = onehot(current) for exactly PULSE cycles (counter counts PULSE-1 down to 0). Then go to GAP with o=0.
  - GAP: o=0 for exactly GAP cycles. done=1 only in the first GAP cycle. At the end of the last GAP cycle:
    - pending valid: move pending into current, clear the pending slot, go to ACTIVE. The next o rises immediately after the gap.
    - pending empty: go to IDLE.
- Request handling while state is not IDLE:
  - Pending empty: latch i into pending.
  - Pending full: drop the request and set ovf=1.
  - A request on the same edge that consumes pending (end of last GAP cycle) refills the freed slot; it is not dropped and ovf is unchanged.
  - A request in IDLE with pending empty goes straight to ACTIVE; pending stays unused.
- Output rules:
  - o is at most one-hot at every cycle.
  - o never changes from one nonzero value to another without at least GAP zero cycles between them.
  - Consecutive pulses to the same index are also separated by a gap.
- Width rules:
  - Counter width is clog2(max(PULSE,GAP)+1).
  - Selector values use the full 2**W range; there is no invalid index.
- busy:
  - Rises on the edge that accepts a request from IDLE.
  - Falls on the edge that enters IDLE.
- req held high continuously is treated as a new request on every sampled edge.

Test Plan:
- Reset, then req=1 with i=3'b101 for one cycle (W=3, PULSE=4, GAP=1) -> o=8'b0000_0100 (o[5]) for cycles 1..4; o=0 and done=1 at cycle 5; busy=0 from cycle 6.
- Back-to-back: req i=0 at cycle 0, req i=7 at cycle 2 -> o[0] for cycles 1..4; gap at cycle 5; o[7] for cycles 6..9; done pulses at cycles 5 and 10; ovf=0.
- Overflow: req at cycles 0, 1, 2 with i=1, 2, 3 -> pulses on o[1] then o[2]; i=3 is dropped; ovf=1 from cycle 3 and stays set until clr.
- Slot refill on consume: pending loaded, then a new req on the last GAP edge -> accepted into pending; three pulses emitted; ovf=0.
- clr asserted mid-ACTIVE at cycle 2 -> o=0, busy=0 asynchronously with no done; a fresh req after release behaves as in the first scenario.
- Parameter sweep W=4, PULSE=1, GAP=3 with req i=4'b1111 -> o[15] high for 1 cycle, then 3 zero cycles with done in the first; no other output ever asserted.
